ir_transmit: RTL and testbench

IR frame transmitter that serialises an 11-bit command word onto a single open-line signal, `sda_out`, in the team's IR line format. The frame is three start falling edges followed by 11 Manchester bits, LSB first. The block sits directly upstream of the IR receive stage and drives the line that stage samples. It is the source side of any board-to-board or loopback IR link.

---
 rtl/ir_transmit.sv | 151 +++++++++++++++
 tb/tb_ir_transmit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmit.sv
// ir_transmit: serialises an 11-bit command word onto the IR line as three start
//   lows followed by 11 Manchester bits, LSB first ('1' = high/low, '0' = low/high).
// Latency: sda_out falls on the accepting clk edge; a frame lasts 27*HALF_CYC cycles.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored, never queued.
// Ports: clk, rst (async active-low), tx_data[10:0]/tx_valid/tx_ready handshake,
//   sda_out (registered line, idles high), tx_busy, tx_done (1-cycle end pulse).
// Option: define IR_TX_GAP_EN to hold the line idle and busy for GAP_CYC cycles
//   after each frame before tx_ready returns.
module ir_transmit #(
    parameter int HALF_CYC = 44500,
    parameter int GAP_CYC  = 178000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        sda_out,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        PRE_LO,
        PRE_HI,
        GUARD,
        BIT_A,
`ifdef IR_TX_GAP_EN
        BIT_B,
        GAP
`else
        BIT_B
`endif
    } state_t;

    localparam logic [31:0] HALF_LAST = 32'(HALF_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] half_cnt;
    logic [31:0] cnt_last;
    logic [1:0]  pre_cnt;
    logic [3:0]  bit_idx;
    logic [10:0] shreg;
    logic [10:0] shreg_nxt;
    logic        sda_nxt;
    logic        done_nxt;
    logic        term;
    logic        accept;

`ifdef IR_TX_GAP_EN
    assign cnt_last = (state == GAP) ? GAP_LAST : HALF_LAST;
`else
    logic [31:0] unused_gap_last;
    assign unused_gap_last = GAP_LAST;
    assign cnt_last        = HALF_LAST;
`endif

    assign term     = (half_cnt == cnt_last);
    assign accept   = (state == IDLE) && tx_valid;
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt = PRE_LO;
                    shreg_nxt = tx_data;
                end
            end
            PRE_LO: if (term) state_nxt = PRE_HI;
            // pre_cnt increments as PRE_HI ends; the post-increment value of 2
            // (i.e. current value 1) marks the second high half of the preamble.
            PRE_HI: if (term) state_nxt = (pre_cnt == 2'd1) ? GUARD : PRE_LO;
            GUARD:  if (term) state_nxt = BIT_A;
            BIT_A:  if (term) state_nxt = BIT_B;
            BIT_B: begin
                if (term) begin
                    shreg_nxt = {1'b0, shreg[10:1]};
                    if (bit_idx == 4'd10) begin
                        done_nxt = 1'b1;
`ifdef IR_TX_GAP_EN
                        state_nxt = GAP;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = BIT_A;
                    end
                end
            end
`ifdef IR_TX_GAP_EN
            GAP: if (term) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase

        // Line level is a function of the state being entered, so sda_out is a
        // plain register aligned with the state register.
        sda_nxt = 1'b1;
        case (state_nxt)
            PRE_LO:  sda_nxt = 1'b0;
            GUARD:   sda_nxt = 1'b0;
            BIT_A:   sda_nxt = shreg_nxt[0];
            BIT_B:   sda_nxt = ~shreg_nxt[0];
            default: sda_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            half_cnt <= 32'd0;
            pre_cnt  <= 2'd0;
            bit_idx  <= 4'd0;
            shreg    <= 11'd0;
            sda_out  <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            sda_out <= sda_nxt;
            tx_done <= done_nxt;

            if ((state == IDLE) || (state_nxt != state)) begin
                half_cnt <= 32'd0;
            end else begin
                half_cnt <= half_cnt + 32'd1;
            end

            if (accept) begin
                pre_cnt <= 2'd0;
            end else if ((state == PRE_HI) && term && (pre_cnt != 2'd2)) begin
                pre_cnt <= pre_cnt + 2'd1;
            end

            if (accept) begin
                bit_idx <= 4'd0;
            end else if ((state == BIT_B) && term && (bit_idx != 4'd10)) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ir_transmit.sv
// tb_ir_transmit: directed bench for ir_transmit with HALF_CYC=10, GAP_CYC=30.
// Expected mid-bit polarities are queued when a word is driven and popped as the
// recorded line waveform is decoded.
module tb_ir_transmit;

    localparam int H = 10;
    localparam int G = 30;
`ifdef IR_TX_GAP_EN
    localparam int READY_AT = 27 * H + G;
    localparam logic BUSY_MID_GAP = 1'b1;
`else
    localparam int READY_AT = 27 * H;
    localparam logic BUSY_MID_GAP = 1'b0;
`endif
    localparam int B2 = READY_AT + 1;
    localparam int N1 = B2 + READY_AT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] tx_data = 11'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        sda_out;
    logic        tx_busy;
    logic        tx_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    logic s [0:699];
    logic d [0:699];
    logic r [0:699];
    logic b [0:699];

    always #5 clk = ~clk;

    ir_transmit #(.HALF_CYC(H), .GAP_CYC(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sda_out  (sda_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [10:0] w);
        for (int k = 0; k < 11; k++) exp_q.push_back(w[k]);
    endtask

    task automatic rec(input int i);
        s[i] = sda_out;
        d[i] = tx_done;
        r[i] = tx_ready;
        b[i] = tx_busy;
    endtask

    // base = sample index taken just after the accepting edge (t0).
    task automatic check_frame(input int base, input string nm);
        int   falls;
        int   idx;
        logic bit_e;
        check({nm, "_t0_low"}, 32'(s[base]), 32'd0);
        check({nm, "_fall_2h"}, 32'({s[base+19], s[base+20]}), 32'd2);
        check({nm, "_fall_4h"}, 32'({s[base+39], s[base+40]}), 32'd2);
        falls = 0;
        for (int i = base + 1; i < base + 60; i++) if (s[i-1] && !s[i]) falls++;
        check({nm, "_pre_falls"}, 32'(falls), 32'd2);
        for (int k = 0; k < 11; k++) begin
            bit_e = exp_q.pop_front();
            idx = base + 6 * H + 2 * H * k;
            check($sformatf("%s_mid%0d", nm, k), 32'({s[idx-1], s[idx]}), 32'({bit_e, ~bit_e}));
        end
        check({nm, "_done_early"}, 32'(d[base+27*H-1]), 32'd0);
        check({nm, "_done"}, 32'(d[base+27*H]), 32'd1);
        check({nm, "_sda_end"}, 32'(s[base+27*H]), 32'd1);
        check({nm, "_ready_pre"}, 32'(r[base+READY_AT-1]), 32'd0);
        check({nm, "_ready"}, 32'(r[base+READY_AT]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cnt_done;
        int cnt_low;
        int cnt_nrdy;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'($urandom);
            tx_data  = 11'($urandom);
            step();
            check($sformatf("rst_sda%0d", i), 32'(sda_out), 32'd1);
            check($sformatf("rst_ready%0d", i), 32'(tx_ready), 32'd1);
            check($sformatf("rst_busy%0d", i), 32'(tx_busy), 32'd0);
            check($sformatf("rst_done%0d", i), 32'(tx_done), 32'd0);
        end
        tx_valid = 1'b0;
        rst = 1'b1;
        step();
        step();

        // Frame 1 (0x0F5), data changed and valid held mid-frame, then frame 2.
        tx_data  = 11'h0F5;
        tx_valid = 1'b1;
        push_word(11'h0F5);
        for (int i = 0; i < N1; i++) begin
            step();
            rec(i);
            if (i == 100) begin
                tx_data = 11'h3A6;
                push_word(11'h3A6);
            end
            if (i == B2) tx_valid = 1'b0;
        end
        check("f1_busy", 32'(b[0]), 32'd1);
        check("f1_ready_low", 32'(r[0]), 32'd0);
        check_frame(0, "f1");
        check_frame(B2, "f2");
        cnt_done = 0;
        for (int i = 0; i < N1; i++) if (d[i]) cnt_done++;
        check("b2b_done_count", 32'(cnt_done), 32'd2);

        // Reset pulse during bit 4 (bit 4 of 0x145 is 0, so the line is low).
        step();
        step();
        tx_data  = 11'h145;
        tx_valid = 1'b1;
        push_word(11'h145);
        for (int i = 0; i < 136; i++) begin
            step();
            rec(i);
            if (i == 0) tx_valid = 1'b0;
        end
        check("rm_t0_low", 32'(s[0]), 32'd0);
        check("rm_bit4_low", 32'(s[135]), 32'd0);
        cnt_done = 0;
        for (int i = 0; i < 136; i++) if (d[i]) cnt_done++;
        check("rm_done_before", 32'(cnt_done), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rm_sda_async", 32'(sda_out), 32'd1);
        check("rm_busy_async", 32'(tx_busy), 32'd0);
        check("rm_ready_async", 32'(tx_ready), 32'd1);
        check("rm_done_async", 32'(tx_done), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        cnt_done = 0;
        cnt_low  = 0;
        cnt_nrdy = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_done) cnt_done++;
            if (!sda_out) cnt_low++;
            if (!tx_ready) cnt_nrdy++;
        end
        check("rm_done_after", 32'(cnt_done), 32'd0);
        check("rm_line_idle", 32'(cnt_low), 32'd0);
        check("rm_ready_after", 32'(cnt_nrdy), 32'd0);

        // Single frame (0x2AA) measuring when tx_ready returns.
        tx_data  = 11'h2AA;
        tx_valid = 1'b1;
        push_word(11'h2AA);
        for (int i = 0; i < READY_AT + 20; i++) begin
            step();
            rec(i);
            if (i == 0) tx_valid = 1'b0;
        end
        check_frame(0, "f4");
        check("f4_busy_gap", 32'(b[27*H+15]), 32'(BUSY_MID_GAP));
        cnt_low = 0;
        for (int i = 27 * H; i < READY_AT + 20; i++) if (!s[i]) cnt_low++;
        check("f4_tail_high", 32'(cnt_low), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
